sobel_filter: RTL
=================

SOBEL_FILTER -- requirements
Module: sobel_filter

Interface
REQ-001 Parameter LINE_WIDTH, default 1280, meaning: max pixels per line; sets line-buffer depth.
REQ-002 Parameter PIX_W, default 12, meaning: pixel width.
REQ-003 iCLK  input  1  sole clock; all logic rising-edge.
REQ-004 iRST  input  1  synchronous, active-high reset.
REQ-005 iDATA  input  12  greyscale pixel from the upstream greyscale stage.
REQ-006 iX_Cont  input  11  column of iDATA.
REQ-007 iY_Cont  input  11  row of iDATA.
REQ-008 iDVAL  input  1  iDATA/iX_Cont/iY_Cont valid this cycle.
REQ-009 iMODE  input  2  00 pass, 01 |Gx|, 10 |Gy|, 11 |Gx|+|Gy|.
REQ-010 oDATA  output  12  filtered pixel.
REQ-011 oX_Cont  output  11  iX_Cont of the pixel that produced oDATA.
REQ-012 oY_Cont  output  11  iY_Cont of the pixel that produced oDATA.
REQ-013 oDVAL  output  1  oDATA/oX_Cont/oY_Cont valid.

Function
REQ-014 Two line buffers, addressed by iX_Cont, shall hold rows y-1 and y-2; on iDVAL, read-before-write at the same address.
REQ-015 The 3x3 window shall shift one column only on iDVAL; columns x-2 (left) to x (right), rows y-2 (top) to y (bottom).
REQ-016 Gx = (TR + 2*MR + BR) - (TL + 2*ML + BL); Gy = (BL + 2*BC + BR) - (TL + 2*TC + TR).
REQ-017 Gx and Gy shall be 16-bit signed; |Gx|+|Gy| shall be 16-bit unsigned; no intermediate overflow allowed.
REQ-018 Result >4095 shall saturate to 4095; mode 00 shall output window centre MC unchanged.
REQ-019 iMODE shall be sampled together with the pixel on iDVAL and travel with it through the pipeline.
REQ-020 Pipeline: stage 1 window/line-buffer read, stage 2 Gx/Gy sums, stage 3 abs/add/saturate/gating.
REQ-021 oDVAL shall assert exactly 3 cycles after each cycle with iDVAL=1; no backpressure; bubbles pass through unchanged.
REQ-022 oX_Cont/oY_Cont shall equal the delayed newest-pixel coordinates (window bottom-right corner).
REQ-023 Border: if pixel iX_Cont<2 or iY_Cont<2, oDATA shall be 0 with oDVAL still 1, in every mode.
REQ-024 iX_Cont>=LINE_WIDTH: pixel shall not be written to the line buffer; oDATA 0, oDVAL 1.
REQ-025 When oDVAL=0, oDATA/oX_Cont/oY_Cont shall hold their last values.

Reset
REQ-026 iRST=1 shall clear window, pipeline valids, oDATA, oX_Cont, oY_Cont, oDVAL to 0 on the next iCLK edge.
REQ-027 Line-buffer RAM contents shall not be cleared; border gating (REQ-023) masks stale data.
REQ-028 Reset mid-line: first oDVAL shall assert 3 cycles after the first post-reset iDVAL; pixels in flight are discarded.

Structure
REQ-029 Package sobel_pkg shall hold PIX_W, COORD_W=11, SUM_W=16 and the iMODE enum (MODE_PASS, MODE_GX, MODE_GY, MODE_MAG).
REQ-030 One sub-module, line_buffer (single-port read-before-write RAM, depth LINE_WIDTH, width PIX_W), instantiated twice.
REQ-031 No other sub-modules; the pipeline lives in sobel_filter.

Verification (LINE_WIDTH=8, 8x8 frame)
REQ-032 Flat field 100, mode 11, continuous iDVAL -> every oDATA=0; oDVAL 3 cycles after each iDVAL.
REQ-033 Columns 0-3=0, 4-7=1000, mode 01 -> oDATA=4000 at x=4,5 for y>=2; all others 0.
REQ-034 Rows 0-3=0, 4-7=4095, mode 10 -> raw 16380 saturates to 4095 at y=4,5; all others 0.
REQ-035 Random image, mode 11, iDVAL toggling 1-0 -> output sequence identical to the continuous-iDVAL run; border pixels 0.
REQ-036 iRST=1 for 1 cycle at pixel (5,3) -> next cycle oDVAL=0, oDATA=0; restart at (0,0) gives first oDVAL 3 cycles later with oDATA=0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared widths, the output-mode encoding and a magnitude helper for the Sobel edge filter.
package sobel_pkg;

   localparam int PIX_W   = 12;
   localparam int COORD_W = 11;
   localparam int SUM_W   = 16;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_GX   = 2'b01,
      MODE_GY   = 2'b10,
      MODE_MAG  = 2'b11
   } mode_e;

   // Gradients never reach -2^15, so negation cannot wrap.
   function automatic logic [SUM_W-1:0] abs_sum(input logic signed [SUM_W-1:0] value);
      return value[SUM_W-1] ? SUM_W'(-value) : SUM_W'(value);
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One video line of pixel storage: asynchronous read, synchronous write, so a write
// in the same cycle as a read returns the previous contents (read-before-write).
module line_buffer
   import sobel_pkg::*;
#(
   parameter int DEPTH = 1280,
   parameter int WIDTH = PIX_W
) (
   input  logic               clk,
   input  logic               we,
   input  logic [COORD_W-1:0] addr,
   input  logic [WIDTH-1:0]   wdata,
   output logic [WIDTH-1:0]   rdata
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] idx;

   assign idx   = addr[ADDR_W-1:0];
   assign rdata = mem[idx];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_filter.sv
// Three-stage streaming 3x3 Sobel filter: window capture, Gx/Gy sums, then
// magnitude, saturation and border gating. Mode and coordinates ride with each pixel.
module sobel_filter
   import sobel_pkg::*;
#(
   parameter int LINE_WIDTH = 1280,
   parameter int PIX_W      = 12
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic [PIX_W-1:0]   iDATA,
   input  logic [COORD_W-1:0] iX_Cont,
   input  logic [COORD_W-1:0] iY_Cont,
   input  logic               iDVAL,
   input  logic [1:0]         iMODE,
   output logic [PIX_W-1:0]   oDATA,
   output logic [COORD_W-1:0] oX_Cont,
   output logic [COORD_W-1:0] oY_Cont,
   output logic               oDVAL
);

   localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(LINE_WIDTH);
   localparam logic [COORD_W-1:0] EDGE    = COORD_W'(2);
   localparam logic [SUM_W-1:0]   PIX_MAX = SUM_W'({PIX_W{1'b1}});

   logic               in_range;
   logic               wr_en;
   logic [PIX_W-1:0]   row1_raw;
   logic [PIX_W-1:0]   row2_raw;
   logic [PIX_W-1:0]   row1;
   logic [PIX_W-1:0]   row2;

   // Out-of-range columns neither write nor read, so they cannot alias a valid address.
   assign in_range = iX_Cont < X_LIMIT;
   assign wr_en    = iDVAL && in_range && !iRST;
   assign row1     = in_range ? row1_raw : '0;
   assign row2     = in_range ? row2_raw : '0;

   line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PIX_W)) line_y1 (
      .clk   (iCLK),
      .we    (wr_en),
      .addr  (iX_Cont),
      .wdata (iDATA),
      .rdata (row1_raw)
   );

   line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PIX_W)) line_y2 (
      .clk   (iCLK),
      .we    (wr_en),
      .addr  (iX_Cont),
      .wdata (row1_raw),
      .rdata (row2_raw)
   );

   logic [2:0][PIX_W-1:0] win_top;
   logic [2:0][PIX_W-1:0] win_mid;
   logic [2:0][PIX_W-1:0] win_bot;
   logic                  s1_valid;
   logic [COORD_W-1:0]    s1_x;
   logic [COORD_W-1:0]    s1_y;
   mode_e                 s1_mode;

   // Index 0 of each window row is the oldest (leftmost) column.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         win_top  <= '0;
         win_mid  <= '0;
         win_bot  <= '0;
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_mode  <= MODE_PASS;
      end else begin
         s1_valid <= iDVAL;
         if (iDVAL) begin
            win_top <= {row2, win_top[2], win_top[1]};
            win_mid <= {row1, win_mid[2], win_mid[1]};
            win_bot <= {iDATA, win_bot[2], win_bot[1]};
            s1_x    <= iX_Cont;
            s1_y    <= iY_Cont;
            s1_mode <= mode_e'(iMODE);
         end
      end
   end

   logic signed [SUM_W-1:0] tl, tc, tr, ml, mr, bl, bc, br;
   logic signed [SUM_W-1:0] gx_next;
   logic signed [SUM_W-1:0] gy_next;
   logic                    border_next;

   assign tl = SUM_W'(win_top[0]);
   assign tc = SUM_W'(win_top[1]);
   assign tr = SUM_W'(win_top[2]);
   assign ml = SUM_W'(win_mid[0]);
   assign mr = SUM_W'(win_mid[2]);
   assign bl = SUM_W'(win_bot[0]);
   assign bc = SUM_W'(win_bot[1]);
   assign br = SUM_W'(win_bot[2]);

   assign gx_next     = (tr + (mr <<< 1) + br) - (tl + (ml <<< 1) + bl);
   assign gy_next     = (bl + (bc <<< 1) + br) - (tl + (tc <<< 1) + tr);
   assign border_next = (s1_x < EDGE) || (s1_y < EDGE) || (s1_x >= X_LIMIT);

   logic                    s2_valid;
   logic signed [SUM_W-1:0] s2_gx;
   logic signed [SUM_W-1:0] s2_gy;
   logic [PIX_W-1:0]        s2_centre;
   logic                    s2_border;
   logic [COORD_W-1:0]      s2_x;
   logic [COORD_W-1:0]      s2_y;
   mode_e                   s2_mode;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         s2_valid  <= 1'b0;
         s2_gx     <= '0;
         s2_gy     <= '0;
         s2_centre <= '0;
         s2_border <= 1'b1;
         s2_x      <= '0;
         s2_y      <= '0;
         s2_mode   <= MODE_PASS;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_gx     <= gx_next;
            s2_gy     <= gy_next;
            s2_centre <= win_mid[1];
            s2_border <= border_next;
            s2_x      <= s1_x;
            s2_y      <= s1_y;
            s2_mode   <= s1_mode;
         end
      end
   end

   logic [SUM_W-1:0] abs_gx;
   logic [SUM_W-1:0] abs_gy;
   logic [SUM_W-1:0] grad;
   logic [PIX_W-1:0] result;

   always_comb begin
      abs_gx = abs_sum(s2_gx);
      abs_gy = abs_sum(s2_gy);
      grad   = '0;
      case (s2_mode)
         MODE_PASS: grad = SUM_W'(s2_centre);
         MODE_GX:   grad = abs_gx;
         MODE_GY:   grad = abs_gy;
         MODE_MAG:  grad = abs_gx + abs_gy;
      endcase
      result = '0;
      if (!s2_border) begin
         result = (grad > PIX_MAX) ? '1 : grad[PIX_W-1:0];
      end
   end

   // Outputs only move on a valid result, so bubbles leave the last pixel visible.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oDATA   <= '0;
         oX_Cont <= '0;
         oY_Cont <= '0;
         oDVAL   <= 1'b0;
      end else begin
         oDVAL <= s2_valid;
         if (s2_valid) begin
            oDATA   <= result;
            oX_Cont <= s2_x;
            oY_Cont <= s2_y;
         end
      end
   end

endmodule
